// File: rtl/tl_ram_responder_if.sv
// TileLink-UL A/D channel pair between a requester and tl_ram_responder.
// Signal names follow the upstream diplomacy-generated "auto_in" naming.
interface tl_ram_responder_if;
    logic        auto_in_a_ready;
    logic        auto_in_a_valid;
    logic [2:0]  auto_in_a_bits_opcode;
    logic [2:0]  auto_in_a_bits_size;
    logic [6:0]  auto_in_a_bits_source;
    logic [31:0] auto_in_a_bits_address;
    logic        auto_in_a_bits_user_amba_prot_bufferable;
    logic        auto_in_a_bits_user_amba_prot_modifiable;
    logic        auto_in_a_bits_user_amba_prot_readalloc;
    logic        auto_in_a_bits_user_amba_prot_writealloc;
    logic        auto_in_a_bits_user_amba_prot_privileged;
    logic        auto_in_a_bits_user_amba_prot_secure;
    logic        auto_in_a_bits_user_amba_prot_fetch;
    logic [7:0]  auto_in_a_bits_mask;
    logic [63:0] auto_in_a_bits_data;
    logic        auto_in_d_ready;
    logic        auto_in_d_valid;
    logic [2:0]  auto_in_d_bits_opcode;
    logic [2:0]  auto_in_d_bits_size;
    logic [6:0]  auto_in_d_bits_source;
    logic        auto_in_d_bits_denied;
    logic [63:0] auto_in_d_bits_data;
    logic        auto_in_d_bits_corrupt;

    modport master (
        input  auto_in_a_ready,
        output auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_size,
               auto_in_a_bits_source, auto_in_a_bits_address,
               auto_in_a_bits_user_amba_prot_bufferable, auto_in_a_bits_user_amba_prot_modifiable,
               auto_in_a_bits_user_amba_prot_readalloc, auto_in_a_bits_user_amba_prot_writealloc,
               auto_in_a_bits_user_amba_prot_privileged, auto_in_a_bits_user_amba_prot_secure,
               auto_in_a_bits_user_amba_prot_fetch, auto_in_a_bits_mask, auto_in_a_bits_data,
               auto_in_d_ready,
        input  auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_size,
               auto_in_d_bits_source, auto_in_d_bits_denied, auto_in_d_bits_data,
               auto_in_d_bits_corrupt
    );

    modport slave (
        output auto_in_a_ready,
        input  auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_size,
               auto_in_a_bits_source, auto_in_a_bits_address,
               auto_in_a_bits_user_amba_prot_bufferable, auto_in_a_bits_user_amba_prot_modifiable,
               auto_in_a_bits_user_amba_prot_readalloc, auto_in_a_bits_user_amba_prot_writealloc,
               auto_in_a_bits_user_amba_prot_privileged, auto_in_a_bits_user_amba_prot_secure,
               auto_in_a_bits_user_amba_prot_fetch, auto_in_a_bits_mask, auto_in_a_bits_data,
               auto_in_d_ready,
        output auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_size,
               auto_in_d_bits_source, auto_in_d_bits_denied, auto_in_d_bits_data,
               auto_in_d_bits_corrupt
    );
endinterface

// File: rtl/tl_ram_responder.sv
// TileLink-UL manager backing a DEPTH x 64-bit RAM window with a 2-entry response queue.
// Optional AMBA prot enforcement is enabled by defining TL_RAM_PROT_CHECK_EN.
module tl_ram_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 512
) (
    input  logic               clock,
    input  logic               reset,
    tl_ram_responder_if.slave  tl
);

    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [31:0] WIN_MASK = ~((32'(DEPTH) * 32'd8) - 32'd1);

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACK         = 3'd0;
    localparam logic [2:0] OP_ACK_DATA    = 3'd1;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  size;
        logic [6:0]  source;
        logic        denied;
        logic        corrupt;
        logic [63:0] data;
    } d_beat_t;

    logic [63:0] mem [DEPTH];
    d_beat_t     q_mem [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;
    logic [1:0]  count_nxt;
    logic        a_ready_q;

    logic             a_fire;
    logic             d_fire;
    logic             in_range;
    logic             misaligned;
    logic             size_bad;
    logic             is_get;
    logic             is_put;
    logic             prot_ok;
    logic             denied;
    logic             wr_en;
    logic [IDX_W-1:0] idx;
    d_beat_t          resp;
    d_beat_t          head_beat;

    assign a_fire = tl.auto_in_a_valid & a_ready_q;
    assign d_fire = (count != 2'd0) & tl.auto_in_d_ready;
    assign idx    = tl.auto_in_a_bits_address[IDX_W+2:3];

`ifdef TL_RAM_PROT_CHECK_EN
    // Puts need privileged access; Gets are allowed if either privileged or secure.
    logic unused_prot;
    assign unused_prot = ^{tl.auto_in_a_bits_user_amba_prot_bufferable,
                           tl.auto_in_a_bits_user_amba_prot_modifiable,
                           tl.auto_in_a_bits_user_amba_prot_readalloc,
                           tl.auto_in_a_bits_user_amba_prot_writealloc,
                           tl.auto_in_a_bits_user_amba_prot_fetch};
    assign prot_ok = is_get ? (tl.auto_in_a_bits_user_amba_prot_privileged |
                               tl.auto_in_a_bits_user_amba_prot_secure)
                            : tl.auto_in_a_bits_user_amba_prot_privileged;
`else
    logic unused_prot;
    assign unused_prot = ^{tl.auto_in_a_bits_user_amba_prot_bufferable,
                           tl.auto_in_a_bits_user_amba_prot_modifiable,
                           tl.auto_in_a_bits_user_amba_prot_readalloc,
                           tl.auto_in_a_bits_user_amba_prot_writealloc,
                           tl.auto_in_a_bits_user_amba_prot_privileged,
                           tl.auto_in_a_bits_user_amba_prot_secure,
                           tl.auto_in_a_bits_user_amba_prot_fetch};
    assign prot_ok = 1'b1;
`endif

    always_comb begin
        in_range   = (tl.auto_in_a_bits_address & WIN_MASK) == BASE_ADDR;
        is_get     = tl.auto_in_a_bits_opcode == OP_GET;
        is_put     = (tl.auto_in_a_bits_opcode == OP_PUT_FULL) ||
                     (tl.auto_in_a_bits_opcode == OP_PUT_PARTIAL);
        size_bad   = 1'b0;
        misaligned = 1'b0;
        case (tl.auto_in_a_bits_size)
            3'd0:    misaligned = 1'b0;
            3'd1:    misaligned = tl.auto_in_a_bits_address[0];
            3'd2:    misaligned = |tl.auto_in_a_bits_address[1:0];
            3'd3:    misaligned = |tl.auto_in_a_bits_address[2:0];
            default: size_bad   = 1'b1;
        endcase
        denied = ~in_range | size_bad | misaligned | ~(is_get | is_put) | ~prot_ok;

        // Unsupported opcodes answer with a plain AccessAck, so only Get maps to AckData.
        resp         = '0;
        resp.opcode  = is_get ? OP_ACK_DATA : OP_ACK;
        resp.size    = tl.auto_in_a_bits_size;
        resp.source  = tl.auto_in_a_bits_source;
        resp.denied  = denied;
        resp.corrupt = is_get & denied;
        resp.data    = (is_get & ~denied) ? mem[idx] : 64'd0;

        wr_en = a_fire & is_put & ~denied;

        case ({a_fire, d_fire})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (tl.auto_in_a_bits_mask[i]) begin
                    mem[idx][i*8 +: 8] <= tl.auto_in_a_bits_data[i*8 +: 8];
                end
            end
        end
    end

    // a_ready is registered from the next count, so d_ready never reaches it combinationally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_mem[0]  <= '0;
            q_mem[1]  <= '0;
            head      <= 1'b0;
            tail      <= 1'b0;
            count     <= 2'd0;
            a_ready_q <= 1'b0;
        end else begin
            if (a_fire) begin
                q_mem[tail] <= resp;
                tail        <= ~tail;
            end
            if (d_fire) begin
                head <= ~head;
            end
            count     <= count_nxt;
            a_ready_q <= count_nxt != 2'd2;
        end
    end

    assign head_beat = (count != 2'd0) ? q_mem[head] : '0;

    assign tl.auto_in_a_ready        = a_ready_q;
    assign tl.auto_in_d_valid        = count != 2'd0;
    assign tl.auto_in_d_bits_opcode  = head_beat.opcode;
    assign tl.auto_in_d_bits_size    = head_beat.size;
    assign tl.auto_in_d_bits_source  = head_beat.source;
    assign tl.auto_in_d_bits_denied  = head_beat.denied;
    assign tl.auto_in_d_bits_corrupt = head_beat.corrupt;
    assign tl.auto_in_d_bits_data    = head_beat.data;

endmodule

// File: tb/tb_tl_ram_responder.sv
// Bench for tl_ram_responder: vector table plus stall, prot and reset sequences,
// with a scoreboard queue of expected D beats compared on each D handshake.
module tb_tl_ram_responder;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [6:0]  src;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
        logic        priv;
        logic        sec;
    } a_req_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  size;
        logic [6:0]  source;
        logic        denied;
        logic        corrupt;
        logic [63:0] data;
    } d_exp_t;

    typedef struct {
        a_req_t a;
        d_exp_t d;
    } vec_t;

    logic clock = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    d_exp_t sb[$];

    tl_ram_responder_if tl_bus ();

    tl_ram_responder #(
        .BASE_ADDR(32'h8000_0000),
        .DEPTH    (512)
    ) dut (
        .clock(clock),
        .reset(rst_n),
        .tl   (tl_bus)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(logic [2:0] op, logic [2:0] sz, logic [6:0] src, logic [31:0] addr,
                                logic [7:0] mask, logic [63:0] wdata,
                                logic [2:0] eop, logic den, logic cor, logic [63:0] edata);
        vec_t v;
        v.a.op   = op;
        v.a.size = sz;
        v.a.src  = src;
        v.a.addr = addr;
        v.a.mask = mask;
        v.a.data = wdata;
        v.a.priv = 1'b1;
        v.a.sec  = 1'b1;
        v.d.opcode  = eop;
        v.d.size    = sz;
        v.d.source  = src;
        v.d.denied  = den;
        v.d.corrupt = cor;
        v.d.data    = edata;
        return v;
    endfunction

    function automatic d_exp_t dut_d();
        d_exp_t d;
        d.opcode  = tl_bus.auto_in_d_bits_opcode;
        d.size    = tl_bus.auto_in_d_bits_size;
        d.source  = tl_bus.auto_in_d_bits_source;
        d.denied  = tl_bus.auto_in_d_bits_denied;
        d.corrupt = tl_bus.auto_in_d_bits_corrupt;
        d.data    = tl_bus.auto_in_d_bits_data;
        return d;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the beat fires.
    task automatic send(input vec_t v);
        int n;
        tl_bus.auto_in_a_bits_opcode  = v.a.op;
        tl_bus.auto_in_a_bits_size    = v.a.size;
        tl_bus.auto_in_a_bits_source  = v.a.src;
        tl_bus.auto_in_a_bits_address = v.a.addr;
        tl_bus.auto_in_a_bits_mask    = v.a.mask;
        tl_bus.auto_in_a_bits_data    = v.a.data;
        tl_bus.auto_in_a_bits_user_amba_prot_privileged = v.a.priv;
        tl_bus.auto_in_a_bits_user_amba_prot_secure     = v.a.sec;
        tl_bus.auto_in_a_valid = 1'b1;
        n = 0;
        while (!tl_bus.auto_in_a_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!tl_bus.auto_in_a_ready) begin
            checks++;
            errors++;
            $display("FAIL a_accept_timeout src=%0d: a_ready stayed 0, required 1", v.a.src);
            tl_bus.auto_in_a_valid = 1'b0;
        end else begin
            sb.push_back(v.d);
            @(negedge clock);
            tl_bus.auto_in_a_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Scoreboard: compare the D head on every handshake, sampled clear of the clock edge.
    always begin
        d_exp_t act;
        d_exp_t exp;
        @(negedge clock);
        #1;
        if (rst_n && tl_bus.auto_in_d_valid && tl_bus.auto_in_d_ready) begin
            act = dut_d();
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL d_unexpected: got beat %h, required no beat", act);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL d_beat src=%0d: got %h expected %h", exp.source, act, exp);
                end
            end
        end
    end

    initial begin
        vec_t   vecs[18];
        vec_t   g1, g2, g3, pv, gv;
        d_exp_t hold;

        vecs[0]  = mk(3'd0, 3'd3, 7'd5,  32'h8000_0008, 8'hFF, 64'h1122334455667788, 3'd0, 1'b0, 1'b0, 64'd0);
        vecs[1]  = mk(3'd4, 3'd3, 7'd9,  32'h8000_0008, 8'h00, 64'd0,                3'd1, 1'b0, 1'b0, 64'h1122334455667788);
        vecs[2]  = mk(3'd1, 3'd0, 7'd3,  32'h8000_0008, 8'h01, 64'h00000000000000AA, 3'd0, 1'b0, 1'b0, 64'd0);
        vecs[3]  = mk(3'd4, 3'd3, 7'd4,  32'h8000_0008, 8'h00, 64'd0,                3'd1, 1'b0, 1'b0, 64'h11223344556677AA);
        vecs[4]  = mk(3'd4, 3'd3, 7'd6,  32'h7FFF_FFF8, 8'h00, 64'd0,                3'd1, 1'b1, 1'b1, 64'd0);
        vecs[5]  = mk(3'd4, 3'd3, 7'd7,  32'h8000_0004, 8'h00, 64'd0,                3'd1, 1'b1, 1'b1, 64'd0);
        vecs[6]  = mk(3'd4, 3'd3, 7'd8,  32'h8000_1000, 8'h00, 64'd0,                3'd1, 1'b1, 1'b1, 64'd0);
        vecs[7]  = mk(3'd0, 3'd3, 7'd10, 32'h8000_0010, 8'hFF, 64'hDEADBEEFCAFEF00D, 3'd0, 1'b0, 1'b0, 64'd0);
        vecs[8]  = mk(3'd0, 3'd4, 7'd11, 32'h8000_0010, 8'hFF, 64'd0,                3'd0, 1'b1, 1'b0, 64'd0);
        vecs[9]  = mk(3'd2, 3'd3, 7'd12, 32'h8000_0010, 8'hFF, 64'd0,                3'd0, 1'b1, 1'b0, 64'd0);
        vecs[10] = mk(3'd1, 3'd3, 7'd13, 32'h8000_0010, 8'hF0, 64'h0102030405060708, 3'd0, 1'b0, 1'b0, 64'd0);
        vecs[11] = mk(3'd4, 3'd2, 7'd14, 32'h8000_0014, 8'h00, 64'd0,                3'd1, 1'b0, 1'b0, 64'h01020304CAFEF00D);
        vecs[12] = mk(3'd4, 3'd1, 7'd15, 32'h8000_0011, 8'h00, 64'd0,                3'd1, 1'b1, 1'b1, 64'd0);
        vecs[13] = mk(3'd4, 3'd0, 7'd16, 32'h8000_0013, 8'h00, 64'd0,                3'd1, 1'b0, 1'b0, 64'h01020304CAFEF00D);
        vecs[14] = mk(3'd0, 3'd3, 7'd17, 32'h8000_0FF8, 8'hFF, 64'h0123456789ABCDEF, 3'd0, 1'b0, 1'b0, 64'd0);
        vecs[15] = mk(3'd4, 3'd3, 7'd18, 32'h8000_0FF8, 8'h00, 64'd0,                3'd1, 1'b0, 1'b0, 64'h0123456789ABCDEF);
        vecs[16] = mk(3'd0, 3'd3, 7'd19, 32'h8000_0FFC, 8'hFF, 64'd0,                3'd0, 1'b1, 1'b0, 64'd0);
        vecs[17] = mk(3'd4, 3'd3, 7'd20, 32'h8000_0FF8, 8'h00, 64'd0,                3'd1, 1'b0, 1'b0, 64'h0123456789ABCDEF);

        tl_bus.auto_in_a_valid        = 1'b0;
        tl_bus.auto_in_a_bits_opcode  = 3'd0;
        tl_bus.auto_in_a_bits_size    = 3'd0;
        tl_bus.auto_in_a_bits_source  = 7'd0;
        tl_bus.auto_in_a_bits_address = 32'd0;
        tl_bus.auto_in_a_bits_mask    = 8'd0;
        tl_bus.auto_in_a_bits_data    = 64'd0;
        tl_bus.auto_in_a_bits_user_amba_prot_bufferable = 1'b0;
        tl_bus.auto_in_a_bits_user_amba_prot_modifiable = 1'b0;
        tl_bus.auto_in_a_bits_user_amba_prot_readalloc  = 1'b0;
        tl_bus.auto_in_a_bits_user_amba_prot_writealloc = 1'b0;
        tl_bus.auto_in_a_bits_user_amba_prot_privileged = 1'b1;
        tl_bus.auto_in_a_bits_user_amba_prot_secure     = 1'b1;
        tl_bus.auto_in_a_bits_user_amba_prot_fetch      = 1'b0;
        tl_bus.auto_in_d_ready = 1'b0;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check_bit("reset_a_ready", tl_bus.auto_in_a_ready, 1'b0);
        check_bit("reset_d_valid", tl_bus.auto_in_d_valid, 1'b0);
        checks++;
        if (dut_d() !== '0) begin
            errors++;
            $display("FAIL reset_d_bits: got %h expected 0", dut_d());
        end
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        #1;
        check_bit("post_reset_a_ready", tl_bus.auto_in_a_ready, 1'b1);

        // Vector table, back-to-back with d_ready held high.
        @(negedge clock);
        tl_bus.auto_in_d_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            send(vecs[i]);
            if (i == 0) begin
                #1;
                check_bit("first_d_latency", tl_bus.auto_in_d_valid, 1'b1);
                @(negedge clock);
            end
        end
        drain();

        // Stall: two Gets fill the queue, the third waits until d_ready returns.
        g1 = mk(3'd4, 3'd3, 7'd21, 32'h8000_0008, 8'h00, 64'd0, 3'd1, 1'b0, 1'b0, 64'h11223344556677AA);
        g2 = mk(3'd4, 3'd3, 7'd22, 32'h8000_0010, 8'h00, 64'd0, 3'd1, 1'b0, 1'b0, 64'h01020304CAFEF00D);
        g3 = mk(3'd4, 3'd3, 7'd23, 32'h8000_0FF8, 8'h00, 64'd0, 3'd1, 1'b0, 1'b0, 64'h0123456789ABCDEF);
        tl_bus.auto_in_d_ready = 1'b0;
        send(g1);
        send(g2);
        #1;
        check_bit("stall_a_ready_low", tl_bus.auto_in_a_ready, 1'b0);
        hold = dut_d();
        checks++;
        if (hold !== g1.d) begin
            errors++;
            $display("FAIL stall_head: got %h expected %h", hold, g1.d);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            #1;
            check_bit("stall_d_valid", tl_bus.auto_in_d_valid, 1'b1);
            checks++;
            if (dut_d() !== hold) begin
                errors++;
                $display("FAIL stall_d_stable: got %h expected %h", dut_d(), hold);
            end
        end
        @(negedge clock);
        tl_bus.auto_in_d_ready = 1'b1;
        send(g3);
        drain();

        // Prot sequence: expectations depend on whether prot checking is built in.
        pv = mk(3'd0, 3'd3, 7'd30, 32'h8000_0008, 8'hFF, 64'd0, 3'd0, 1'b0, 1'b0, 64'd0);
        pv.a.priv = 1'b0;
        gv = mk(3'd4, 3'd3, 7'd31, 32'h8000_0008, 8'h00, 64'd0, 3'd1, 1'b0, 1'b0, 64'd0);
`ifdef TL_RAM_PROT_CHECK_EN
        pv.d.denied = 1'b1;
        gv.d.data   = 64'h11223344556677AA;
`endif
        send(pv);
        send(gv);
        gv = mk(3'd4, 3'd3, 7'd32, 32'h8000_0010, 8'h00, 64'd0, 3'd1, 1'b0, 1'b0, 64'h01020304CAFEF00D);
        gv.a.priv = 1'b0;
        gv.a.sec  = 1'b0;
`ifdef TL_RAM_PROT_CHECK_EN
        gv.d.denied  = 1'b1;
        gv.d.corrupt = 1'b1;
        gv.d.data    = 64'd0;
`endif
        send(gv);
        drain();

        // Reset with two responses queued: they are dropped and never appear.
        tl_bus.auto_in_d_ready = 1'b0;
        send(mk(3'd4, 3'd3, 7'd40, 32'h8000_0008, 8'h00, 64'd0, 3'd1, 1'b0, 1'b0, 64'd0));
        send(mk(3'd4, 3'd3, 7'd41, 32'h8000_0010, 8'h00, 64'd0, 3'd1, 1'b0, 1'b0, 64'd0));
        #2 rst_n = 1'b0;
        #1;
        check_bit("async_reset_d_valid", tl_bus.auto_in_d_valid, 1'b0);
        check_bit("async_reset_a_ready", tl_bus.auto_in_a_ready, 1'b0);
        sb.delete();
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        #1;
        check_bit("rerelease_a_ready", tl_bus.auto_in_a_ready, 1'b1);
        check_bit("rerelease_d_valid", tl_bus.auto_in_d_valid, 1'b0);
        @(negedge clock);
        tl_bus.auto_in_d_ready = 1'b1;
        repeat (4) @(negedge clock);
        send(mk(3'd4, 3'd3, 7'd42, 32'h8000_0FF8, 8'h00, 64'd0, 3'd1, 1'b0, 1'b0, 64'h0123456789ABCDEF));
        drain();

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
